// File: rtl/icache_pkg.sv
// Shared types and index-splitting helpers for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        FILL        = 2'd1,
        REFILL_DONE = 2'd2
    } state_e;

    localparam int unsigned SPLIT_W = 64;

    typedef struct packed {
        logic [SPLIT_W-1:0] tag;
        logic [SPLIT_W-1:0] set;
        logic [SPLIT_W-1:0] off;
    } idx_split_t;

    function automatic int unsigned off_w(input int unsigned line_words);
        return $clog2(line_words);
    endfunction

    function automatic int unsigned set_w(input int unsigned lines);
        return $clog2(lines);
    endfunction

    function automatic int unsigned tag_w(input int unsigned idx_w, input int unsigned line_words,
                                          input int unsigned lines);
        return idx_w - off_w(line_words) - set_w(lines);
    endfunction

    // Fields come back zero-extended; callers truncate to their own widths.
    function automatic idx_split_t split_index(input logic [SPLIT_W-1:0] idx,
                                               input int unsigned ow, input int unsigned sw);
        idx_split_t         s;
        logic [SPLIT_W-1:0] off_mask;
        logic [SPLIT_W-1:0] set_mask;
        off_mask = (SPLIT_W'(1) << ow) - SPLIT_W'(1);
        set_mask = (SPLIT_W'(1) << sw) - SPLIT_W'(1);
        s.off    = idx & off_mask;
        s.set    = (idx >> ow) & set_mask;
        s.tag    = idx >> (ow + sw);
        return s;
    endfunction

endpackage

// File: rtl/icache_ram.sv
// Single-port data array: one synchronous write or one read per cycle.
module icache_ram #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 6
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_c_o
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_c_o = mem_q[addr_i];

endmodule

// File: rtl/icache_dm.sv
// Direct-mapped instruction cache: 1-cycle hits, line refill over a req/ack bus on miss.
module icache_dm
    import icache_pkg::*;
#(
    parameter int unsigned IDX_W      = 32,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned LINES      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              not_enable,
    input  logic [IDX_W-1:0]  index,
    input  logic              flush,
    output logic [DATA_W-1:0] data,
    output logic              data_valid,
    output logic              stall,
    output logic              mem_req,
    output logic [IDX_W-1:0]  mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_data
);

    localparam int unsigned OFF_W  = off_w(LINE_WORDS);
    localparam int unsigned SET_W  = set_w(LINES);
    localparam int unsigned TAG_W  = tag_w(IDX_W, LINE_WORDS, LINES);
    localparam int unsigned RAM_AW = SET_W + OFF_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(LINE_WORDS - 1);

    idx_split_t         req_split;
    logic               unused_split;
    logic [TAG_W-1:0]   req_tag;
    logic [SET_W-1:0]   req_set;
    logic [OFF_W-1:0]   req_off;

    state_e                        state_q, state_d;
    logic [LINES-1:0]              valid_q, valid_d;
    logic [LINES-1:0][TAG_W-1:0]   tag_q, tag_d;
    logic [DATA_W-1:0]             data_q, data_d;
    logic                          data_valid_q, data_valid_d;
    logic                          stall_q, stall_d;
    logic                          mem_req_q, mem_req_d;
    logic [IDX_W-1:0]              mem_addr_q, mem_addr_d;
    logic [OFF_W-1:0]              beat_q, beat_d;
    logic                          flush_pend_q, flush_pend_d;
    logic [SET_W-1:0]              miss_set_q, miss_set_d;
    logic [TAG_W-1:0]              miss_tag_q, miss_tag_d;

    logic                          hit;
    logic                          ram_we;
    logic [RAM_AW-1:0]             ram_addr;
    logic [DATA_W-1:0]             ram_rdata;

    assign req_split    = split_index(SPLIT_W'(index), OFF_W, SET_W);
    assign req_tag      = TAG_W'(req_split.tag);
    assign req_set      = SET_W'(req_split.set);
    assign req_off      = OFF_W'(req_split.off);
    assign unused_split = ^req_split;

    assign hit = valid_q[req_set] && (tag_q[req_set] == req_tag);

    // The single RAM port belongs to the refill while filling, otherwise to lookup.
    assign ram_we   = (state_q == FILL) && mem_ack;
    assign ram_addr = (state_q == FILL) ? {miss_set_q, beat_q} : {req_set, req_off};

    icache_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (RAM_AW)
    ) u_ram (
        .clk       (clk),
        .we_i      (ram_we),
        .addr_i    (ram_addr),
        .wdata_i   (mem_data),
        .rdata_c_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            tag_q        <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            stall_q      <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            beat_q       <= '0;
            flush_pend_q <= 1'b0;
            miss_set_q   <= '0;
            miss_tag_q   <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            tag_q        <= tag_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            stall_q      <= stall_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            beat_q       <= beat_d;
            flush_pend_q <= flush_pend_d;
            miss_set_q   <= miss_set_d;
            miss_tag_q   <= miss_tag_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        tag_d        = tag_q;
        data_d       = '0;
        data_valid_d = 1'b0;
        stall_d      = stall_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        beat_d       = beat_q;
        flush_pend_d = flush_pend_q;
        miss_set_d   = miss_set_q;
        miss_tag_d   = miss_tag_q;

        case (state_q)
            IDLE: begin
                if (flush) begin
                    valid_d = '0;
                end else if (!not_enable) begin
                    if (hit) begin
                        data_d       = ram_rdata;
                        data_valid_d = 1'b1;
                    end else begin
                        state_d             = FILL;
                        stall_d             = 1'b1;
                        mem_req_d           = 1'b1;
                        mem_addr_d          = {req_tag, req_set, OFF_W'(0)};
                        beat_d              = '0;
                        miss_set_d          = req_set;
                        miss_tag_d          = req_tag;
                        valid_d[req_set]    = 1'b0;
                    end
                end
            end
            FILL: begin
                flush_pend_d = flush_pend_q | flush;
                if (mem_ack) begin
                    if (beat_q == LAST_BEAT) begin
                        // A flush seen at any point of the fill leaves the line invalid.
                        tag_d[miss_set_q]   = miss_tag_q;
                        valid_d[miss_set_q] = !(flush_pend_q || flush);
                        state_d             = REFILL_DONE;
                        stall_d             = 1'b0;
                        mem_req_d           = 1'b0;
                        beat_d              = '0;
                    end else begin
                        beat_d     = beat_q + OFF_W'(1);
                        mem_addr_d = {miss_tag_q, miss_set_q, beat_q + OFF_W'(1)};
                    end
                end
            end
            REFILL_DONE: begin
                state_d      = IDLE;
                flush_pend_d = 1'b0;
                if (flush_pend_q || flush) begin
                    valid_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data       = data_q;
    assign data_valid = data_valid_q;
    assign stall      = stall_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;

endmodule
